// File: rtl/spi_pkg.sv
// Shared SPI definitions: byte width, bit-counter width and SPI_MODE -> CPOL/CPHA decode.
package spi_pkg;

    localparam int SPI_BYTE_W = 8;
    localparam int SPI_CNT_W  = 3;

    typedef logic [SPI_BYTE_W-1:0] spi_byte_t;

    function automatic logic spi_cpol(input int mode);
        return (mode == 2) || (mode == 3);
    endfunction

    function automatic logic spi_cpha(input int mode);
        return (mode == 1) || (mode == 3);
    endfunction

endpackage

// File: rtl/spi_edge_detect.sv
// SPI input conditioning: optional 2-flop synchronizers (SPI_SLAVE_SYNC_EN) and
// leading/trailing SPI clock edge pulses relative to CPOL.
module spi_edge_detect
    import spi_pkg::*;
#(
    parameter logic CPOL = 1'b0
)
(
    input  logic clk,
    input  logic srst,
    input  logic spi_clk,
    input  logic spi_cs_n,
    input  logic spi_mosi,
    output logic cs_n,
    output logic mosi,
    output logic lead_pulse,
    output logic trail_pulse
);

    logic [2:0] raw;
    logic [2:0] sync;
    logic       spi_clk_reg;
    logic       rise;
    logic       fall;

    assign raw = {spi_clk, spi_cs_n, spi_mosi};

`ifdef SPI_SLAVE_SYNC_EN
    // Reset values match the idle bus: clock at CPOL, chip deselected.
    localparam logic [2:0] SYNC_INIT = {CPOL, 1'b1, 1'b0};
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            logic meta_reg;
            logic stable_reg;
            always_ff @(posedge clk) begin
                if (srst) begin
                    meta_reg   <= SYNC_INIT[gi];
                    stable_reg <= SYNC_INIT[gi];
                end else begin
                    meta_reg   <= raw[gi];
                    stable_reg <= meta_reg;
                end
            end
            assign sync[gi] = stable_reg;
        end
    endgenerate
`else
    assign sync = raw;
`endif

    always_ff @(posedge clk) begin
        if (srst) begin
            spi_clk_reg <= CPOL;
        end else begin
            spi_clk_reg <= sync[2];
        end
    end

    assign rise        = sync[2] & ~spi_clk_reg;
    assign fall        = ~sync[2] & spi_clk_reg;
    assign lead_pulse  = CPOL ? fall : rise;
    assign trail_pulse = CPOL ? rise : fall;
    assign cs_n        = sync[1];
    assign mosi        = sync[0];

endmodule

// File: rtl/spi_slave.sv
// SPI slave (modes 0-3), MSB first, back-to-back bytes under one CS_n frame.
// Define SPI_SLAVE_SYNC_EN to synchronize the SPI inputs into i_Clk.
module spi_slave
    import spi_pkg::*;
#(
    parameter int SPI_MODE = 0
)
(
    input  logic       i_Clk,
    input  logic       i_Rst,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    input  logic       i_TX_DV,
    input  logic [7:0] i_TX_Byte,
    input  logic       i_SPI_Clk,
    output logic       o_SPI_MISO,
    input  logic       i_SPI_MOSI,
    input  logic       i_SPI_CS_n
);

    localparam logic CPOL = spi_cpol(SPI_MODE);
    localparam logic CPHA = spi_cpha(SPI_MODE);

    logic                  cs_n_s;
    logic                  mosi_s;
    logic                  lead_pulse;
    logic                  trail_pulse;
    logic                  sample_evt;
    logic                  shift_evt;
    logic                  cs_fall;
    logic                  load_evt;
    logic                  cs_n_prev_reg;
    logic [SPI_CNT_W-1:0]  bit_cnt_reg;
    logic [SPI_BYTE_W-2:0] rx_shift_reg;
    spi_byte_t             rx_byte_reg;
    logic                  rx_dv_reg;
    spi_byte_t             tx_hold_reg;
    spi_byte_t             tx_shift_reg;
    spi_byte_t             tx_shift_next;
    spi_byte_t             tx_load;
    logic                  miso_reg;
    logic                  miso_next;

    spi_edge_detect #(
        .CPOL (CPOL)
    ) u_edge_detect (
        .clk         (i_Clk),
        .srst        (i_Rst),
        .spi_clk     (i_SPI_Clk),
        .spi_cs_n    (i_SPI_CS_n),
        .spi_mosi    (i_SPI_MOSI),
        .cs_n        (cs_n_s),
        .mosi        (mosi_s),
        .lead_pulse  (lead_pulse),
        .trail_pulse (trail_pulse)
    );

    assign sample_evt = ~cs_n_s & (CPHA ? trail_pulse : lead_pulse);
    assign shift_evt  = ~cs_n_s & (CPHA ? lead_pulse : trail_pulse);
    assign cs_fall    = cs_n_prev_reg & ~cs_n_s;
    // A byte starts on CS_n falling or right after the previous byte completed.
    assign load_evt   = cs_fall | (rx_dv_reg & ~cs_n_s);
    assign tx_load    = i_TX_DV ? i_TX_Byte : tx_hold_reg;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            cs_n_prev_reg <= 1'b1;
            bit_cnt_reg   <= '0;
            rx_shift_reg  <= '0;
            rx_byte_reg   <= '0;
            rx_dv_reg     <= 1'b0;
        end else begin
            cs_n_prev_reg <= cs_n_s;
            rx_dv_reg     <= 1'b0;
            if (cs_n_s) begin
                bit_cnt_reg <= '0;
            end else if (sample_evt) begin
                rx_shift_reg <= {rx_shift_reg[SPI_BYTE_W-3:0], mosi_s};
                bit_cnt_reg  <= bit_cnt_reg + SPI_CNT_W'(1);
                if (&bit_cnt_reg) begin
                    rx_byte_reg <= {rx_shift_reg, mosi_s};
                    rx_dv_reg   <= 1'b1;
                end
            end
        end
    end

    // CPHA=0 presents the MSB at load time, so the 8th trailing edge (counter
    // already wrapped to 0) must not shift; CPHA=1 presents every bit on a leading edge.
    always_comb begin
        tx_shift_next = tx_shift_reg;
        miso_next     = miso_reg;
        if (load_evt) begin
            if (CPHA) begin
                tx_shift_next = tx_load;
            end else begin
                miso_next     = tx_load[SPI_BYTE_W-1];
                tx_shift_next = {tx_load[SPI_BYTE_W-2:0], 1'b0};
            end
        end else if (shift_evt && (CPHA || (bit_cnt_reg != '0))) begin
            miso_next     = tx_shift_reg[SPI_BYTE_W-1];
            tx_shift_next = {tx_shift_reg[SPI_BYTE_W-2:0], 1'b0};
        end
        if (cs_n_s) begin
            miso_next = 1'b1;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            tx_hold_reg  <= '0;
            tx_shift_reg <= '0;
            miso_reg     <= 1'b1;
        end else begin
            if (i_TX_DV) begin
                tx_hold_reg <= i_TX_Byte;
            end
            tx_shift_reg <= tx_shift_next;
            miso_reg     <= miso_next;
        end
    end

    assign o_RX_DV    = rx_dv_reg;
    assign o_RX_Byte  = rx_byte_reg;
    assign o_SPI_MISO = miso_reg;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: one instance per SPI mode, SPI master
// driven from tasks, expectations from a per-mode TX-holding model.
module tb_spi_slave;

`ifdef SPI_SLAVE_SYNC_EN
    localparam int HP = 4;
`else
    localparam int HP = 2;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sclk = 4'b1100;
    logic [3:0] cs_n = 4'hF;
    logic [3:0] mosi = 4'h0;
    logic [3:0] tb_tx_dv = 4'h0;
    logic [3:0] loop_en = 4'h0;
    logic       miso [4];
    logic       rx_dv [4];
    logic       dut_tx_dv [4];
    logic [7:0] rx_byte [4];
    logic [7:0] tb_tx_byte [4];
    logic [7:0] dut_tx_byte [4];

    int         n_tests = 0;
    int         n_fail = 0;
    int         rxlog[$];
    logic [7:0] hold_model [4];
    logic [7:0] mo_buf [8];
    logic [7:0] mi_buf [8];
    logic [7:0] exp_rx_buf [8];
    logic [7:0] exp_mi_buf [8];

    typedef struct {
        int         mode;
        logic       do_load;
        logic [7:0] preload;
        logic [7:0] mtx;
        logic [7:0] exp_srx;
        logic [7:0] exp_mrx;
    } vec_t;
    vec_t vecs [8];

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dut
            assign dut_tx_dv[gi]   = loop_en[gi] ? rx_dv[gi] : tb_tx_dv[gi];
            assign dut_tx_byte[gi] = loop_en[gi] ? rx_byte[gi] : tb_tx_byte[gi];
            spi_slave #(
                .SPI_MODE (gi)
            ) u_dut (
                .i_Clk      (clk),
                .i_Rst      (rst),
                .o_RX_DV    (rx_dv[gi]),
                .o_RX_Byte  (rx_byte[gi]),
                .i_TX_DV    (dut_tx_dv[gi]),
                .i_TX_Byte  (dut_tx_byte[gi]),
                .i_SPI_Clk  (sclk[gi]),
                .o_SPI_MISO (miso[gi]),
                .i_SPI_MOSI (mosi[gi]),
                .i_SPI_CS_n (cs_n[gi])
            );
        end
    endgenerate

    // Each cycle rx_dv is high produces one log entry, so a stretched pulse shows up as an extra byte.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rx_dv[k] === 1'b1) rxlog.push_back(k * 256 + int'(rx_byte[k]));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic preload(input int m, input logic [7:0] v);
        tb_tx_byte[m] = v;
        tb_tx_dv[m]   = 1'b1;
        tick(1);
        tb_tx_dv[m]   = 1'b0;
        hold_model[m] = v;
    endtask

    // Master side of nb bits, MSB first; returns the MISO bits it sampled.
    task automatic xfer_bits(input int m, input logic [7:0] mo, input int nb, output logic [7:0] mi);
        logic pol;
        logic pha;
        pol = (m >= 2);
        pha = (m % 2 == 1);
        mi  = 8'h00;
        for (int i = 7; i > 7 - nb; i--) begin
            if (!pha) begin
                mosi[m] = mo[i];
                tick(HP);
                sclk[m] = ~pol;
                mi[i]   = miso[m];
                tick(HP);
                sclk[m] = pol;
            end else begin
                tick(HP);
                sclk[m] = ~pol;
                mosi[m] = mo[i];
                tick(HP);
                sclk[m] = pol;
                mi[i]   = miso[m];
            end
        end
    endtask

    task automatic run_frame(input int m, input int n, input string tag);
        int act;
        rxlog.delete();
        cs_n[m] = 1'b0;
        tick(HP);
        for (int b = 0; b < n; b++) xfer_bits(m, mo_buf[b], 8, mi_buf[b]);
        tick(HP);
        cs_n[m] = 1'b1;
        tick(2 * HP + 2);
        check($sformatf("%s m%0d rx_dv count", tag, m), rxlog.size(), n);
        for (int b = 0; b < n; b++) begin
            act = (b < rxlog.size()) ? rxlog[b] : -1;
            check($sformatf("%s m%0d slave rx[%0d]", tag, m, b), act, m * 256 + int'(exp_rx_buf[b]));
            check($sformatf("%s m%0d master rx[%0d]", tag, m, b), mi_buf[b], exp_mi_buf[b]);
            $display("[TB] %s mode %0d byte %0d: master sent %02h, master got %02h (want %02h), slave want %02h",
                     tag, m, b, mo_buf[b], mi_buf[b], exp_mi_buf[b], exp_rx_buf[b]);
        end
    endtask

    task automatic partial(input int m, input int nb, input string tag);
        logic [7:0] mi;
        rxlog.delete();
        cs_n[m] = 1'b0;
        tick(HP);
        xfer_bits(m, 8'($urandom), nb, mi);
        tick(HP);
        cs_n[m] = 1'b1;
        tick(2 * HP + 2);
        check($sformatf("%s m%0d aborted after %0d bits", tag, m, nb), rxlog.size(), 0);
        $display("[TB] %s mode %0d: CS_n raised after %0d bits", tag, m, nb);
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            hold_model[k] = 8'h00;
            tb_tx_byte[k] = 8'h00;
        end
        vecs[0] = '{1, 1'b1, 8'h5A, 8'hC1, 8'hC1, 8'h5A};
        vecs[1] = '{1, 1'b0, 8'h00, 8'h3E, 8'h3E, 8'h5A};
        vecs[2] = '{0, 1'b1, 8'hA5, 8'h96, 8'h96, 8'hA5};
        vecs[3] = '{2, 1'b1, 8'hA5, 8'h96, 8'h96, 8'hA5};
        vecs[4] = '{3, 1'b1, 8'hA5, 8'h96, 8'h96, 8'hA5};
        vecs[5] = '{0, 1'b1, 8'h00, 8'hFF, 8'hFF, 8'h00};
        vecs[6] = '{3, 1'b1, 8'hFF, 8'h00, 8'h00, 8'hFF};
        vecs[7] = '{2, 1'b1, 8'h01, 8'h80, 8'h80, 8'h01};

        tick(4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("reset m%0d rx_dv", k), rx_dv[k], 1'b0);
            check($sformatf("reset m%0d rx_byte", k), rx_byte[k], 8'h00);
            check($sformatf("reset m%0d miso", k), miso[k], 1'b1);
        end
        rst = 1'b0;
        tick(2);

        // Directed single-byte vectors across modes.
        for (int v = 0; v < 8; v++) begin
            if (vecs[v].do_load) preload(vecs[v].mode, vecs[v].preload);
            mo_buf[0]     = vecs[v].mtx;
            exp_rx_buf[0] = vecs[v].exp_srx;
            exp_mi_buf[0] = vecs[v].exp_mrx;
            run_frame(vecs[v].mode, 1, $sformatf("vec%0d", v));
        end

        // Loopback: each received byte is echoed in the following byte slot.
        for (int li = 0; li < 2; li++) begin
            int m;
            m = (li == 0) ? 0 : 3;
            preload(m, 8'hC1);
            mo_buf[0] = 8'h00; mo_buf[1] = 8'h01; mo_buf[2] = 8'h80;
            mo_buf[3] = 8'hFF; mo_buf[4] = 8'h55; mo_buf[5] = 8'hAA;
            for (int b = 0; b < 6; b++) begin
                exp_rx_buf[b] = mo_buf[b];
                exp_mi_buf[b] = (b == 0) ? hold_model[m] : mo_buf[b-1];
            end
            loop_en[m] = 1'b1;
            run_frame(m, 6, "loopback");
            loop_en[m] = 1'b0;
            hold_model[m] = mo_buf[5];
        end

        // Aborted byte followed by a full one.
        for (int m = 0; m < 2; m++) begin
            partial(m, 5, "abort");
            mo_buf[0]     = 8'h3C;
            exp_rx_buf[0] = 8'h3C;
            exp_mi_buf[0] = hold_model[m];
            run_frame(m, 1, "after_abort");
        end

        // Reset in the middle of a byte.
        begin
            logic [7:0] mi;
            cs_n[0] = 1'b0;
            tick(HP);
            xfer_bits(0, 8'hA7, 4, mi);
            tick(1);
            rst = 1'b1;
            tick(1);
            check("midreset rx_dv", rx_dv[0], 1'b0);
            check("midreset rx_byte", rx_byte[0], 8'h00);
            check("midreset miso", miso[0], 1'b1);
            $display("[TB] reset asserted mid-byte in mode 0");
            cs_n[0] = 1'b1;
            tick(2);
            rst = 1'b0;
            for (int k = 0; k < 4; k++) hold_model[k] = 8'h00;
            tick(2);
            mo_buf[0]     = 8'h69;
            exp_rx_buf[0] = 8'h69;
            exp_mi_buf[0] = 8'h00;
            run_frame(0, 1, "after_reset");
        end

        // Randomized frames against the holding-register model.
        for (int it = 0; it < 30; it++) begin
            int m;
            int n;
            m = $urandom_range(0, 3);
            n = $urandom_range(1, 3);
            if ($urandom_range(0, 1) == 1) preload(m, 8'($urandom));
            if ($urandom_range(0, 3) == 0) partial(m, $urandom_range(1, 7), "rand_abort");
            for (int b = 0; b < n; b++) begin
                mo_buf[b]     = 8'($urandom);
                exp_rx_buf[b] = mo_buf[b];
                exp_mi_buf[b] = hold_model[m];
            end
            run_frame(m, n, $sformatf("rand%0d", it));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
